// File: rtl/dp_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit A,B -> C datapath between NREQ requesters.
// Optional per-operation completion counter (OP_CNT) is enabled by defining DP_ARB_CNT_EN.
module dp_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 4,
  parameter int OP_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] A_IN,
  input  logic [NREQ*WIDTH-1:0] B_IN,
  output logic [NREQ-1:0]       GNT,
  output logic [WIDTH-1:0]      DP_A,
  output logic [WIDTH-1:0]      DP_B,
  output logic                  DP_START,
  input  logic [WIDTH-1:0]      DP_C,
  output logic [NREQ-1:0]       DONE,
  output logic [WIDTH-1:0]      C_OUT
`ifdef DP_ARB_CNT_EN
  ,
  output logic [7:0]            OP_CNT
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]    CNT_INIT = 4'(OP_LAT);
  localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT             state, nextState;
  logic [PW-1:0]     ptr, ptrNext;
  logic [3:0]        cnt, cntNext;

  logic              reqHit;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     cand;
  logic [NREQ-1:0]   winOneHot;
  logic [WIDTH-1:0]  selA, selB;
  logic              lastBusy;

  logic [NREQ-1:0]   gntNext, doneNext;
  logic [WIDTH-1:0]  dpANext, dpBNext, cOutNext;
  logic              startNext;

  // Index reached by stepping 'off' places past base, wrapping at NREQ.
  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    reqHit = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int off = 1; off <= NREQ; off++) begin
      cand = wrapAdd(ptr, off);
      if (!reqHit && REQ[cand]) begin
        reqHit = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    selA      = '0;
    selB      = '0;
    winOneHot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) begin
        selA         = A_IN[i*WIDTH +: WIDTH];
        selB         = B_IN[i*WIDTH +: WIDTH];
        winOneHot[i] = 1'b1;
      end
    end
  end

  assign lastBusy = (state == BUSY) && (cnt == 4'd1);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (reqHit) nextState = BUSY;
      BUSY:    if (cnt == 4'd1) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and bookkeeping.
  always_comb begin
    gntNext   = GNT;
    dpANext   = DP_A;
    dpBNext   = DP_B;
    startNext = 1'b0;
    doneNext  = '0;
    cOutNext  = C_OUT;
    cntNext   = cnt;
    ptrNext   = ptr;
    case (state)
      IDLE: begin
        if (reqHit) begin
          gntNext   = winOneHot;
          dpANext   = selA;
          dpBNext   = selB;
          startNext = 1'b1;
          cntNext   = CNT_INIT;
          ptrNext   = winner;
        end
      end
      BUSY: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) begin
          cOutNext = DP_C;
          doneNext = GNT;
        end
      end
      RESP: begin
        gntNext = '0;
      end
      default: begin
        gntNext = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GNT      <= '0;
      DP_A     <= '0;
      DP_B     <= '0;
      DP_START <= 1'b0;
      DONE     <= '0;
      C_OUT    <= '0;
      cnt      <= '0;
      ptr      <= PTR_RST;
    end else begin
      GNT      <= gntNext;
      DP_A     <= dpANext;
      DP_B     <= dpBNext;
      DP_START <= startNext;
      DONE     <= doneNext;
      C_OUT    <= cOutNext;
      cnt      <= cntNext;
      ptr      <= ptrNext;
    end
  end

`ifdef DP_ARB_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OP_CNT <= '0;
    end else if (lastBusy) begin
      OP_CNT <= OP_CNT + 8'd1;
    end
  end
`endif

endmodule
